// File: rtl/regfile_pkg.sv
// Shared defaults for the regfile_sb register bank.
package regfile_pkg;
  localparam int unsigned DATA_W_DEF    = 32;
  localparam int unsigned NUM_REGS_DEF  = 8;
  localparam int unsigned NUM_RD_DEF    = 2;
  localparam int unsigned ZERO_REG_ADDR = 0;
endpackage

// File: rtl/regfile_sb_if.sv
// Decode / writeback / load-return bus into the register bank.
interface regfile_sb_if #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ADDR_W   = $clog2(NUM_REGS)
);
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     wa_en;
  logic [ADDR_W-1:0]        wa_addr;
  logic [DATA_W-1:0]        wa_data;
  logic                     wb_en;
  logic [ADDR_W-1:0]        wb_addr;
  logic [DATA_W-1:0]        wb_data;
  logic                     iss_en;
  logic [ADDR_W-1:0]        iss_addr;
  logic                     any_busy;

  modport master (
    output rd_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
           iss_en, iss_addr,
    input  rd_data, rd_busy, any_busy
  );

  modport slave (
    input  rd_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
           iss_en, iss_addr,
    output rd_data, rd_busy, any_busy
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Per-register outstanding-load tracker with same-cycle clear forwarding.
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REGS = NUM_REGS_DEF,
  parameter int unsigned NUM_RD   = NUM_RD_DEF,
  parameter int unsigned ADDR_W   = $clog2(NUM_REGS),
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic                     wb_en,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic                     any_busy
);
  logic [NUM_REGS-1:0] busy_q, busy_d;

  // Clear first, then set, so a same-address issue/return leaves the bit busy.
  always_comb begin
    busy_d = busy_q;
    if (wb_en) busy_d[wb_addr] = 1'b0;
    if (iss_en && !(ZERO_REG && iss_addr == ADDR_W'(ZERO_REG_ADDR)))
      busy_d[iss_addr] = 1'b1;
    if (!reset_n) busy_d = '0;
  end

  always_ff @(posedge clk) begin
    busy_q <= busy_d;
  end

  assign any_busy = |busy_q;

  always_comb begin
    rd_busy = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      rd_busy[i] = busy_q[rd_addr[i*ADDR_W +: ADDR_W]] &
                   ~(wb_en && wb_addr == rd_addr[i*ADDR_W +: ADDR_W]);
    end
  end
endmodule

// File: rtl/regfile_sb.sv
// Register bank with two write ports, write-through bypass and load scoreboard.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned NUM_REGS = NUM_REGS_DEF,
  parameter int unsigned ADDR_W   = $clog2(NUM_REGS),
  parameter int unsigned NUM_RD   = NUM_RD_DEF,
  parameter bit          ZERO_REG = 1'b1
) (
  input logic         clk,
  input logic         reset_n,
  regfile_sb_if.slave bus
);
  localparam logic [ADDR_W-1:0] ZADDR = ADDR_W'(ZERO_REG_ADDR);

  logic [DATA_W-1:0] mem_q [NUM_REGS];
  logic [DATA_W-1:0] mem_d [NUM_REGS];

  // Port B applied before port A so A wins on an address collision.
  always_comb begin
    mem_d = mem_q;
    if (bus.wb_en && !(ZERO_REG && bus.wb_addr == ZADDR))
      mem_d[bus.wb_addr] = bus.wb_data;
    if (bus.wa_en && !(ZERO_REG && bus.wa_addr == ZADDR))
      mem_d[bus.wa_addr] = bus.wa_data;
    if (!reset_n) mem_d = '{default: '0};
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] word;

    assign addr = bus.rd_addr[i*ADDR_W +: ADDR_W];

    always_comb begin
      word = mem_q[addr];
      if (bus.wb_en && bus.wb_addr == addr) word = bus.wb_data;
      if (bus.wa_en && bus.wa_addr == addr) word = bus.wa_data;
      if (ZERO_REG && addr == ZADDR) word = '0;
    end

    assign bus.rd_data[i*DATA_W +: DATA_W] = word;
  end

  reg_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_RD   (NUM_RD),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .reset_n  (reset_n),
    .iss_en   (bus.iss_en),
    .iss_addr (bus.iss_addr),
    .wb_en    (bus.wb_en),
    .wb_addr  (bus.wb_addr),
    .rd_addr  (bus.rd_addr),
    .rd_busy  (bus.rd_busy),
    .any_busy (bus.any_busy)
  );
endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: reference model expectations queued per sample.
module tb_regfile_sb;
  logic clk = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk = ~clk;

  regfile_sb_if #(.DATA_W(32), .NUM_REGS(8), .NUM_RD(2)) bus ();

  regfile_sb #(
    .DATA_W   (32),
    .NUM_REGS (8),
    .NUM_RD   (2),
    .ZERO_REG (1'b1)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  busy;
    logic        any;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_reg [8];
  logic [7:0]  m_busy;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [2:0] a);
    if (a == 3'd0) return 32'h0;
    if (bus.wa_en && bus.wa_addr == a) return bus.wa_data;
    if (bus.wb_en && bus.wb_addr == a) return bus.wb_data;
    return m_reg[a];
  endfunction

  function automatic logic m_rbusy(input logic [2:0] a);
    return m_busy[a] && !(bus.wb_en && bus.wb_addr == a);
  endfunction

  task automatic idle();
    bus.wa_en = 1'b0; bus.wb_en = 1'b0; bus.iss_en = 1'b0;
  endtask

  task automatic set_rd(input logic [2:0] a0, input logic [2:0] a1);
    bus.rd_addr = {a1, a0};
  endtask

  // Sample shortly after the falling edge, while inputs are stable.
  task automatic sample();
    exp_t e;
    exp_t got;
    @(negedge clk);
    e.d0   = m_read(bus.rd_addr[2:0]);
    e.d1   = m_read(bus.rd_addr[5:3]);
    e.busy = {m_rbusy(bus.rd_addr[5:3]), m_rbusy(bus.rd_addr[2:0])};
    e.any  = |m_busy;
    exp_q.push_back(e);
    #1;
    got = exp_q.pop_front();
    check_eq("rd_data0", bus.rd_data[31:0],  got.d0);
    check_eq("rd_data1", bus.rd_data[63:32], got.d1);
    check_eq("rd_busy",  {30'd0, bus.rd_busy}, {30'd0, got.busy});
    check_eq("any_busy", {31'd0, bus.any_busy}, {31'd0, got.any});
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) m_reg[i] = 32'h0;
      m_busy = 8'h0;
    end else begin
      if (bus.wb_en && bus.wb_addr != 3'd0) m_reg[bus.wb_addr] = bus.wb_data;
      if (bus.wa_en && bus.wa_addr != 3'd0) m_reg[bus.wa_addr] = bus.wa_data;
      if (bus.wb_en) m_busy[bus.wb_addr] = 1'b0;
      if (bus.iss_en && bus.iss_addr != 3'd0) m_busy[bus.iss_addr] = 1'b1;
    end
    #1;
  endtask

  task automatic step();
    sample();
    tick();
  endtask

  initial begin
    for (int i = 0; i < 8; i++) m_reg[i] = 32'hX;
    m_busy = 8'hX;
    bus.rd_addr = '0; bus.wa_addr = '0; bus.wa_data = '0;
    bus.wb_addr = '0; bus.wb_data = '0; bus.iss_addr = '0;
    idle();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;

    for (int a = 0; a < 8; a++) begin
      set_rd(3'(a), 3'(7 - a));
      step();
    end

    // Write-through bypass and hold.
    set_rd(3'd3, 3'd0);
    bus.wa_en = 1'b1; bus.wa_addr = 3'd3; bus.wa_data = 32'hDEADBEEF;
    sample();
    check_eq("wa_bypass", bus.rd_data[31:0], 32'hDEADBEEF);
    tick();
    idle();
    sample();
    check_eq("wa_hold", bus.rd_data[31:0], 32'hDEADBEEF);
    tick();

    // Register 0 stays zero.
    bus.wa_en = 1'b1; bus.wa_addr = 3'd0; bus.wa_data = 32'h1234;
    set_rd(3'd0, 3'd0);
    step();
    idle();
    sample();
    check_eq("r0_zero", bus.rd_data[31:0], 32'h0);
    tick();

    // Same-address dual write: port A wins.
    bus.wa_en = 1'b1; bus.wa_addr = 3'd5; bus.wa_data = 32'hAAAA0000;
    bus.wb_en = 1'b1; bus.wb_addr = 3'd5; bus.wb_data = 32'h5555FFFF;
    set_rd(3'd5, 3'd5);
    step();
    idle();
    sample();
    check_eq("dual_wr", bus.rd_data[63:32], 32'hAAAA0000);
    tick();

    // Load issue, busy visibility, return with clear-bypass.
    bus.iss_en = 1'b1; bus.iss_addr = 3'd6;
    set_rd(3'd0, 3'd6);
    sample();
    check_eq("iss_not_same_cycle", {31'd0, bus.rd_busy[1]}, 32'd0);
    tick();
    idle();
    sample();
    check_eq("busy_set", {31'd0, bus.rd_busy[1]}, 32'd1);
    check_eq("any_set", {31'd0, bus.any_busy}, 32'd1);
    tick();
    step();
    bus.wb_en = 1'b1; bus.wb_addr = 3'd6; bus.wb_data = 32'h77;
    sample();
    check_eq("clr_bypass_busy", {31'd0, bus.rd_busy[1]}, 32'd0);
    check_eq("clr_bypass_data", bus.rd_data[63:32], 32'h77);
    tick();
    idle();
    sample();
    check_eq("busy_cleared", {31'd0, bus.any_busy}, 32'd0);
    tick();

    // Same-cycle issue and return: set wins, data written.
    bus.iss_en = 1'b1; bus.iss_addr = 3'd2;
    bus.wb_en = 1'b1; bus.wb_addr = 3'd2; bus.wb_data = 32'h22;
    set_rd(3'd2, 3'd1);
    step();
    idle();
    sample();
    check_eq("set_wins", {31'd0, bus.rd_busy[0]}, 32'd1);
    check_eq("set_wins_data", bus.rd_data[31:0], 32'h22);
    tick();
    bus.wb_en = 1'b1; bus.wb_addr = 3'd2; bus.wb_data = 32'h23;
    step();
    idle();

    // Issue to register 0 is ignored.
    bus.iss_en = 1'b1; bus.iss_addr = 3'd0;
    set_rd(3'd0, 3'd0);
    step();
    idle();
    sample();
    check_eq("iss_r0", {31'd0, bus.any_busy}, 32'd0);
    tick();

    // Reset forgets outstanding loads and data.
    bus.iss_en = 1'b1; bus.iss_addr = 3'd4;
    bus.wa_en = 1'b1; bus.wa_addr = 3'd4; bus.wa_data = 32'h44;
    set_rd(3'd4, 3'd4);
    step();
    idle();
    reset_n = 1'b0;
    bus.wa_en = 1'b1; bus.wa_addr = 3'd1; bus.wa_data = 32'h11;
    bus.iss_en = 1'b1; bus.iss_addr = 3'd1;
    tick();
    idle();
    reset_n = 1'b1;
    set_rd(3'd4, 3'd1);
    sample();
    check_eq("rst_busy4", {31'd0, bus.rd_busy[0]}, 32'd0);
    check_eq("rst_data4", bus.rd_data[31:0], 32'h0);
    check_eq("rst_data1", bus.rd_data[63:32], 32'h0);
    check_eq("rst_any", {31'd0, bus.any_busy}, 32'd0);
    tick();

    // Randomised traffic against the model.
    for (int n = 0; n < 300; n++) begin
      reset_n      = ($urandom_range(0, 39) != 0);
      bus.wa_en    = $urandom_range(0, 1) == 1;
      bus.wb_en    = $urandom_range(0, 2) == 0;
      bus.iss_en   = $urandom_range(0, 2) == 0;
      bus.wa_addr  = 3'($urandom_range(0, 7));
      bus.wb_addr  = 3'($urandom_range(0, 7));
      bus.iss_addr = 3'($urandom_range(0, 7));
      bus.wa_data  = $urandom;
      bus.wb_data  = $urandom;
      set_rd(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised register file with write-through bypass, two write ports and a per-register load scoreboard. It is the next generation of the processor's 8×32 register bank. It sits between decode (read ports, scoreboard issue) and the writeback/memory-return paths. It lets the core issue multi-cycle loads and stall dependent instructions without a separate hazard unit.

## Interface
- DATA_W, 32, register width in bits
- NUM_REGS, 8, number of registers (power of two, ≥2)
- ADDR_W, $clog2(NUM_REGS), register address width
- NUM_RD, 2, number of read ports (1–4)
- ZERO_REG, 1, 1 = register 0 hardwired to zero and never busy

- clk  in  1  single clock, rising edge
- reset_n  in  1  synchronous, active-low reset
- rd_addr  in  NUM_RD*ADDR_W  read addresses, port i at bits [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, combinational
- rd_busy  out  NUM_RD  addressed register has an outstanding load
- wa_en  in  1  write port A (ALU writeback) enable
- wa_addr  in  ADDR_W  write port A address
- wa_data  in  DATA_W  write port A data
- wb_en  in  1  write port B (load return) enable
- wb_addr  in  ADDR_W  write port B address
- wb_data  in  DATA_W  write port B data
- iss_en  in  1  load issue: mark iss_addr busy
- iss_addr  in  ADDR_W  destination of issued load
- any_busy  out  1  OR of all busy bits (registered state)

## Operation
- Storage: NUM_REGS × DATA_W registers and NUM_REGS busy bits.
- Writes take effect at the rising edge when the enable is high. Writes to register 0 are dropped when ZERO_REG=1.
- Both ports write the same address in the same cycle: port A wins, and port B data is discarded.
- Bypass: a read of an address written this cycle returns the write data combinationally. Port A data takes precedence over port B data.
- Read of register 0 with ZERO_REG=1 always returns 0 and rd_busy=0.
- Scoreboard:
  - iss_en sets busy[iss_addr] at the next edge (ignored for register 0 when ZERO_REG=1).
  - wb_en clears busy[wb_addr] at the next edge.
  - iss_en and wb_en on the same address in the same cycle: set wins, so busy stays 1.
  - Port A writes do not touch busy bits.
- rd_busy[i] = busy[rd_addr_i] AND NOT (wb_en AND wb_addr==rd_addr_i). A same-cycle load return forwards, so no stall.
- rd_busy does not see a same-cycle iss_en. A set becomes visible from the next cycle.
- iss_en to an already-busy register: stays busy, no error. The upstream stage guarantees one outstanding load per register.
- wb_en to a non-busy register: data is written and busy stays 0.

## Timing
- Read path: rd_data and rd_busy are purely combinational from rd_addr, storage, busy and the write/issue inputs.
- Write latency: 1 cycle. New value appears in storage after the edge and in rd_data immediately via bypass.
- Scoreboard latency: set 1 cycle, clear 0 cycles via bypass / 1 cycle in storage.
- Reset, reset_n=0 at an edge:
  - All registers become 0, all busy bits become 0, and any_busy becomes 0.
  - Writes and issues in that cycle are ignored.
  - Outstanding loads are forgotten: a later wb_en simply writes data.
- Outputs during reset are combinational functions of the cleared state, so rd_data=0 and rd_busy=0 one cycle after the reset edge.

## Structure
- Package regfile_pkg: default DATA_W/NUM_REGS/NUM_RD constants and the ZERO_REG address constant.
- Sub-module reg_scoreboard: NUM_REGS busy bits, set/clear priority, any_busy, and per-port rd_busy with clear-bypass. It is instantiated once.
- Top: storage array, write arbitration, read muxes with bypass, and generate loop over NUM_RD.

## Test plan
- Reset then read all addresses on both ports -> rd_data=0, rd_busy=0, any_busy=0.
- wa_en addr 3 data 0xDEADBEEF while rd_addr0=3 -> rd_data0=0xDEADBEEF in the same cycle, and it holds after the edge. wa_en addr 0 data 0x1234 -> register 0 still reads 0.
- wa_en and wb_en both addr 5, data 0xAAAA0000 / 0x5555FFFF -> register 5 = 0xAAAA0000.
- iss_en addr 6, next cycle rd_addr1=6 -> rd_busy1=1, any_busy=1. Two cycles later, wb_en addr 6 data 0x77 with rd_addr1=6 -> rd_busy1=0 and rd_data1=0x77 in the same cycle, and busy is clear after the edge.
- iss_en and wb_en both addr 2 in the same cycle -> busy[2]=1 afterwards and register 2 holds the wb data. iss_en addr 0 -> any_busy stays 0.
- iss_en addr 4, then reset_n=0 for one cycle -> busy[4]=0 and register 4 = 0.
